clk_div_multi: RTL and testbench

Parametrised multi-channel programmable clock/strobe generator. Successor to the single-channel toggle divider. Each channel has its own counter, a selectable output mode (50% toggle, single-cycle pulse, programmable duty) and a one-cycle period tick. Configuration is double-buffered: writes land in a shadow register and take effect only at a period boundary, so the output never glitches. It sits beside the SoC clock/reset logic and drives sample strobes and slow peripheral clocks.

---
 rtl/clk_div_pkg.sv | 32 +++
 rtl/clk_div_multi_chan.sv | 133 +++++++++++++
 rtl/clk_div_multi.sv | 67 ++++++
 tb/tb_clk_div_multi.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
// Shared types for the multi-channel clock/strobe generator.
//   mode_e  : output mode of a channel (toggle, pulse, duty, reserved)
//   cfg_t   : one channel configuration {mode, div, high} at the default
//             counter width, handy for models and software-side helpers
//   chSelWidth : width of a channel-select field for a given channel count
// ---------------------------------------------------------------------------
package clk_div_pkg;

   localparam int PKG_CNT_W = 16;

   typedef enum logic [1:0] {
      MODE_TOGGLE = 2'd0,
      MODE_PULSE  = 2'd1,
      MODE_DUTY   = 2'd2,
      MODE_RSVD   = 2'd3
   } mode_e;

   typedef struct packed {
      mode_e                mode;
      logic [PKG_CNT_W-1:0] div;
      logic [PKG_CNT_W-1:0] high;
   } cfg_t;

   // A single channel still needs a one-bit select so the port never
   // collapses to zero width.
   function automatic int chSelWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clk_div_multi_chan.sv
// ---------------------------------------------------------------------------
// clk_div_chan
// One channel of the clock/strobe generator: period counter, shadow and
// active configuration, apply-at-boundary logic and the output mode mux.
// Ports:
//   i_clk         : clock, all logic on its rising edge
//   i_reset       : synchronous active-high reset
//   i_en          : channel enable (level)
//   i_cfgWe       : configuration write aimed at this channel
//   i_cfgMode     : mode for the write
//   i_cfgDiv      : period divisor for the write
//   i_cfgHigh     : high time for the write (duty mode)
//   o_clkOut      : registered divided output
//   o_tick        : registered one-cycle strobe at each period wrap
//   o_cfgPending  : a shadow configuration is waiting to be applied
// ---------------------------------------------------------------------------
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int DEF_DIV = 2
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_en,
   input  logic             i_cfgWe,
   input  logic [1:0]       i_cfgMode,
   input  logic [CNT_W-1:0] i_cfgDiv,
   input  logic [CNT_W-1:0] i_cfgHigh,
   output logic             o_clkOut,
   output logic             o_tick,
   output logic             o_cfgPending
);

   localparam logic [CNT_W-1:0] DEF_DIV_V  = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] DEF_HIGH_V = CNT_W'(DEF_DIV >> 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_phase;
   logic             r_out;
   logic             r_tick;
   logic             r_pending;
   mode_e            r_modeA;
   logic [CNT_W-1:0] r_divA;
   logic [CNT_W-1:0] r_highA;
   mode_e            r_modeS;
   logic [CNT_W-1:0] r_divS;
   logic [CNT_W-1:0] r_highS;

   logic [CNT_W-1:0] w_divEff;
   logic [CNT_W-1:0] w_lastCnt;
   logic             w_wrap;
   logic             w_apply;
   logic             w_modeChange;
   logic             w_duty;

   // A divisor of zero is treated as one, which also guarantees the
   // subtraction below can never wrap around. Using >= rather than == keeps
   // the counter bounded even if it ever sits beyond the last count.
   always_comb begin
      w_divEff     = (r_divA == '0) ? CNT_W'(1) : r_divA;
      w_lastCnt    = w_divEff - CNT_W'(1);
      w_wrap       = (r_cnt >= w_lastCnt);
      w_apply      = r_pending & (~i_en | w_wrap);
      w_modeChange = w_apply & (r_modeS != r_modeA);
      w_duty       = (r_cnt < r_highA);
   end

   // Counter and registered outputs. The outputs for an edge are always
   // derived from the active configuration in force before that edge, so a
   // configuration applied on a wrap only governs the following period.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
         r_out   <= 1'b0;
         r_tick  <= 1'b0;
      end else if (!i_en) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
         r_out   <= 1'b0;
         r_tick  <= 1'b0;
      end else begin
         r_cnt  <= w_wrap ? '0 : r_cnt + CNT_W'(1);
         r_tick <= w_wrap;
         case (r_modeA)
            MODE_TOGGLE: begin
               r_phase <= r_phase ^ w_wrap;
               r_out   <= r_phase ^ w_wrap;
            end
            MODE_PULSE: r_out <= w_wrap;
            MODE_DUTY:  r_out <= w_duty;
            default:    r_out <= 1'b0;
         endcase
         if (w_modeChange) begin
            r_phase <= 1'b0;
         end
      end
   end

   // Double-buffered configuration. A write arriving on the same edge as an
   // apply lands in the shadow after the old shadow has been copied across,
   // so it stays pending for the next boundary.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_modeA   <= MODE_TOGGLE;
         r_divA    <= DEF_DIV_V;
         r_highA   <= DEF_HIGH_V;
         r_modeS   <= MODE_TOGGLE;
         r_divS    <= DEF_DIV_V;
         r_highS   <= DEF_HIGH_V;
         r_pending <= 1'b0;
      end else begin
         if (w_apply) begin
            r_modeA   <= r_modeS;
            r_divA    <= r_divS;
            r_highA   <= r_highS;
            r_pending <= 1'b0;
         end
         if (i_cfgWe) begin
            r_modeS   <= mode_e'(i_cfgMode);
            r_divS    <= i_cfgDiv;
            r_highS   <= i_cfgHigh;
            r_pending <= 1'b1;
         end
      end
   end

   assign o_clkOut     = r_out;
   assign o_tick       = r_tick;
   assign o_cfgPending = r_pending;

endmodule

// File: rtl/clk_div_multi.sv
// ---------------------------------------------------------------------------
// clk_div_multi
// Multi-channel programmable clock/strobe generator. Decodes the shared
// configuration write bus onto the channels and instantiates one
// clk_div_chan per channel.
// Ports:
//   clk_in       : single clock, all logic on its rising edge
//   reset        : synchronous active-high reset
//   ch_en        : per-channel enable (level)
//   cfg_we       : one-cycle configuration write strobe
//   cfg_ch       : target channel of the write (out-of-range writes dropped)
//   cfg_mode     : 0 toggle, 1 pulse, 2 duty, 3 reserved
//   cfg_div      : period divisor
//   cfg_high     : high time in cycles (duty mode)
//   clk_out      : per-channel divided outputs
//   tick         : per-channel period-wrap strobes
//   cfg_pending  : per-channel shadow-not-yet-applied flags
// ---------------------------------------------------------------------------
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter  int NCH     = 2,
   parameter  int CNT_W   = 16,
   parameter  int DEF_DIV = 2,
   localparam int CH_W    = chSelWidth(NCH)
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic [NCH-1:0]   ch_en,
   input  logic             cfg_we,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [1:0]       cfg_mode,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic [CNT_W-1:0] cfg_high,
   output logic [NCH-1:0]   clk_out,
   output logic [NCH-1:0]   tick,
   output logic [NCH-1:0]   cfg_pending
);

   logic           w_chValid;
   logic [NCH-1:0] w_chWe;

   // The select field can encode more values than there are channels when
   // NCH is not a power of two; such writes are dropped here.
   assign w_chValid = ({{(32-CH_W){1'b0}}, cfg_ch} < 32'(NCH));

   for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      assign w_chWe[gi] = cfg_we & w_chValid & (cfg_ch == CH_W'(gi));

      clk_div_chan #(
         .CNT_W   (CNT_W),
         .DEF_DIV (DEF_DIV)
      ) u_chan (
         .i_clk        (clk_in),
         .i_reset      (reset),
         .i_en         (ch_en[gi]),
         .i_cfgWe      (w_chWe[gi]),
         .i_cfgMode    (cfg_mode),
         .i_cfgDiv     (cfg_div),
         .i_cfgHigh    (cfg_high),
         .o_clkOut     (clk_out[gi]),
         .o_tick       (tick[gi]),
         .o_cfgPending (cfg_pending[gi])
      );
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// ---------------------------------------------------------------------------
// tb_clk_div_multi
// Scoreboard bench for clk_div_multi with three channels. A reference model
// advances on every rising edge from the driven inputs and queues the
// expected outputs; a monitor pops and compares on every falling edge.
// ---------------------------------------------------------------------------
module tb_clk_div_multi;
   import clk_div_pkg::*;

   localparam int NCH     = 3;
   localparam int CNT_W   = 16;
   localparam int DEF_DIV = 2;
   localparam int CH_W    = 2;

   logic             clk_in = 1'b0;
   logic             reset  = 1'b1;
   logic [NCH-1:0]   ch_en  = '0;
   logic             cfg_we = 1'b0;
   logic [CH_W-1:0]  cfg_ch = '0;
   logic [1:0]       cfg_mode = '0;
   logic [CNT_W-1:0] cfg_div  = '0;
   logic [CNT_W-1:0] cfg_high = '0;
   logic [NCH-1:0]   clk_out;
   logic [NCH-1:0]   tick;
   logic [NCH-1:0]   cfg_pending;

   typedef struct packed {
      logic [NCH-1:0] out;
      logic [NCH-1:0] tick;
      logic [NCH-1:0] pend;
   } exp_t;

   exp_t expQ[$];
   int   checks  = 0;
   int   errors  = 0;
   bit   started = 1'b0;

   int             mCnt[NCH];
   bit             mPhase[NCH];
   bit             mPend[NCH];
   cfg_t           mAct[NCH];
   cfg_t           mShd[NCH];
   logic [NCH-1:0] mOut  = '0;
   logic [NCH-1:0] mTick = '0;

   clk_div_multi #(
      .NCH     (NCH),
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
   ) dut (
      .clk_in      (clk_in),
      .reset       (reset),
      .ch_en       (ch_en),
      .cfg_we      (cfg_we),
      .cfg_ch      (cfg_ch),
      .cfg_mode    (cfg_mode),
      .cfg_div     (cfg_div),
      .cfg_high    (cfg_high),
      .clk_out     (clk_out),
      .tick        (tick),
      .cfg_pending (cfg_pending)
   );

   always #5 clk_in = ~clk_in;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour: one clock edge worth of the channel rules.
   task automatic modelStep();
      if (reset) begin
         for (int k = 0; k < NCH; k++) begin
            mCnt[k]   = 0;
            mPhase[k] = 1'b0;
            mPend[k]  = 1'b0;
            mAct[k]   = '{MODE_TOGGLE, 16'(DEF_DIV), 16'(DEF_DIV >> 1)};
            mShd[k]   = mAct[k];
            mOut[k]   = 1'b0;
            mTick[k]  = 1'b0;
         end
      end else begin
         for (int k = 0; k < NCH; k++) begin
            int divEff;
            int oldCnt;
            bit wrap;
            bit applyNow;
            divEff   = (mAct[k].div == 0) ? 1 : int'(mAct[k].div);
            oldCnt   = mCnt[k];
            wrap     = (oldCnt >= divEff - 1);
            applyNow = mPend[k] && (!ch_en[k] || wrap);
            if (!ch_en[k]) begin
               mCnt[k]   = 0;
               mPhase[k] = 1'b0;
               mOut[k]   = 1'b0;
               mTick[k]  = 1'b0;
            end else begin
               mTick[k] = wrap;
               mCnt[k]  = wrap ? 0 : oldCnt + 1;
               case (mAct[k].mode)
                  MODE_TOGGLE: begin
                     mPhase[k] = mPhase[k] ^ wrap;
                     mOut[k]   = mPhase[k];
                  end
                  MODE_PULSE: mOut[k] = wrap;
                  MODE_DUTY:  mOut[k] = (oldCnt < int'(mAct[k].high));
                  default:    mOut[k] = 1'b0;
               endcase
            end
            if (applyNow) begin
               if (mShd[k].mode != mAct[k].mode) mPhase[k] = 1'b0;
               mAct[k]  = mShd[k];
               mPend[k] = 1'b0;
            end
            if (cfg_we && int'(cfg_ch) == k) begin
               mShd[k]  = '{mode_e'(cfg_mode), cfg_div, cfg_high};
               mPend[k] = 1'b1;
            end
         end
      end
   endtask

   // Expected-response producer: runs on the same edge the DUT samples.
   always @(posedge clk_in) begin
      exp_t e;
      modelStep();
      for (int k = 0; k < NCH; k++) e.pend[k] = mPend[k];
      e.out  = mOut;
      e.tick = mTick;
      expQ.push_back(e);
      started = 1'b1;
   end

   // Monitor: compares the DUT outputs against the oldest queued response.
   initial begin
      forever begin
         exp_t e;
         @(negedge clk_in);
         if (started) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL scoreboard_empty: got no expected entry at %0t", $time);
            end else begin
               e = expQ.pop_front();
               checkOutput("clk_out", 32'(clk_out), 32'(e.out));
               checkOutput("tick", 32'(tick), 32'(e.tick));
               checkOutput("cfg_pending", 32'(cfg_pending), 32'(e.pend));
            end
         end
      end
   end

   task automatic applyStimulus(input bit rst, input logic [NCH-1:0] en, input bit we,
                                input logic [CH_W-1:0] ch, input logic [1:0] mode,
                                input int div, input int high);
      @(negedge clk_in);
      reset    = rst;
      ch_en    = en;
      cfg_we   = we;
      cfg_ch   = ch;
      cfg_mode = mode;
      cfg_div  = 16'(div);
      cfg_high = 16'(high);
   endtask

   task automatic idle(input logic [NCH-1:0] en, input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, en, 1'b0, '0, 2'd0, 0, 0);
   endtask

   initial begin
      bit             togOut[8]  = '{0, 1, 1, 0, 0, 1, 1, 0};
      bit             togTick[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
      logic [NCH-1:0] en;

      applyStimulus(1'b1, '0, 1'b0, '0, 2'd0, 0, 0);
      applyStimulus(1'b1, '0, 1'b0, '0, 2'd0, 0, 0);

      // Default toggle divide-by-2 on channel 0 straight out of reset.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 3'b001, 1'b0, '0, 2'd0, 0, 0);
         @(posedge clk_in);
         #1;
         checkOutput($sformatf("default_toggle_out[%0d]", i), 32'(clk_out[0]), 32'(togOut[i]));
         checkOutput($sformatf("default_toggle_tick[%0d]", i), 32'(tick[0]), 32'(togTick[i]));
      end

      // Pulse div 5 written mid-period, then duty patterns on channel 1.
      applyStimulus(1'b0, 3'b011, 1'b1, 2'd0, 2'd1, 5, 0);
      idle(3'b011, 12);
      applyStimulus(1'b0, 3'b011, 1'b1, 2'd1, 2'd2, 10, 3);
      idle(3'b011, 25);
      applyStimulus(1'b0, 3'b011, 1'b1, 2'd1, 2'd2, 10, 0);
      idle(3'b011, 22);
      applyStimulus(1'b0, 3'b011, 1'b1, 2'd1, 2'd2, 10, 12);
      idle(3'b011, 22);
      applyStimulus(1'b0, 3'b011, 1'b1, 2'd1, 2'd1, 0, 0);
      idle(3'b011, 12);

      // Two writes in one period, then writes on every edge across an apply.
      applyStimulus(1'b0, 3'b011, 1'b1, 2'd1, 2'd0, 4, 0);
      idle(3'b011, 1);
      applyStimulus(1'b0, 3'b011, 1'b1, 2'd1, 2'd0, 7, 0);
      idle(3'b011, 20);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 3'b011, 1'b1, 2'd1, 2'd1, 3 + i, 0);
      idle(3'b011, 15);

      // Disable channel 1 mid-count with a write while it is off.
      applyStimulus(1'b0, 3'b001, 1'b0, '0, 2'd0, 0, 0);
      applyStimulus(1'b0, 3'b001, 1'b1, 2'd1, 2'd2, 6, 2);
      applyStimulus(1'b0, 3'b001, 1'b0, '0, 2'd0, 0, 0);
      idle(3'b011, 15);

      // Out-of-range channel select and reserved mode.
      applyStimulus(1'b0, 3'b111, 1'b1, 2'd3, 2'd1, 9, 0);
      applyStimulus(1'b0, 3'b111, 1'b1, 2'd2, 2'd3, 3, 0);
      idle(3'b111, 10);

      // Reset in the middle of activity, with a write pending on channel 2.
      applyStimulus(1'b0, 3'b111, 1'b1, 2'd2, 2'd2, 9, 4);
      applyStimulus(1'b1, 3'b111, 1'b1, 2'd0, 2'd1, 3, 0);
      @(posedge clk_in);
      #1;
      checkOutput("reset_clk_out", 32'(clk_out), 32'h0);
      checkOutput("reset_tick", 32'(tick), 32'h0);
      checkOutput("reset_pending", 32'(cfg_pending), 32'h0);
      idle(3'b111, 10);

      // Randomised traffic.
      en = 3'b111;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) en = en ^ NCH'(1 << $urandom_range(0, NCH - 1));
         applyStimulus(($urandom_range(0, 299) == 0), en, ($urandom_range(0, 5) == 0),
                       CH_W'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       int'($urandom_range(0, 12)), int'($urandom_range(0, 14)));
      end
      idle(en, 3);

      @(posedge clk_in);
      @(negedge clk_in);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
